fetch_stage: RTL and testbench

Program-counter and IF/ID pipeline register that drives the instruction memory's read address and captures the returned word for decode. Sits directly upstream of the `I_M` instruction memory (combinational read, 256 words, byte address `>>2`) and directly upstream of the decoder. Handles sequential fetch, stalls, taken-branch/jump redirects with one-bubble flush, and address-fault detection.

---
 rtl/fetch_stage.sv | 83 ++++++++
 tb/tb_fetch_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: program counter and IF/ID pipeline register with redirect flush and address-fault tracking
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_instr,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic        addr_fault,
    output logic [31:0] fetch_cnt
);
    localparam logic [31:0] PC_LIMIT = 32'(IM_WORDS) << 2;

    logic [31:0] pc_q, pc_d, instr_q, instr_d, idpc_q, idpc_d, idpc4_q, idpc4_d, cnt_q, cnt_d;
    logic        valid_q, valid_d, fault_q, fault_d;
    logic [31:0] pc_plus4;
    logic        in_range;

    assign pc_plus4 = pc_q + 32'd4;
    assign in_range = pc_q < PC_LIMIT;

    // next state: redirect flushes and retargets, stall holds, otherwise fetch sequentially
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        idpc_d  = idpc_q;
        idpc4_d = idpc4_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        if (redirect) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            instr_d = 32'h0;
            valid_d = 1'b0;
            fault_d = fault_q | (redirect_pc[1:0] != 2'b00);
        end else if (!stall) begin
            pc_d    = pc_plus4;
            instr_d = in_range ? im_instr : 32'h0;
            idpc_d  = pc_q;
            idpc4_d = pc_plus4;
            valid_d = in_range;
            cnt_d   = cnt_q + {31'b0, in_range};
            fault_d = fault_q | ~in_range;
        end
    end

    // state registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            idpc_q  <= 32'h0;
            idpc4_q <= 32'h0;
            valid_q <= 1'b0;
            cnt_q   <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            idpc_q  <= idpc_d;
            idpc4_q <= idpc4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign im_addr     = pc_q;
    assign id_instr    = instr_q;
    assign id_pc       = idpc_q;
    assign id_pc_plus4 = idpc4_q;
    assign id_valid    = valid_q;
    assign addr_fault  = fault_q;
    assign fetch_cnt   = cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus randomized checks of fetch_stage against a behavioural model
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] im_addr, im_instr, id_instr, id_pc, id_pc_plus4, fetch_cnt;
    logic        id_valid, addr_fault;
    logic [31:0] mem [256];

    int tests = 0;
    int failed = 0;

    logic [31:0] m_pc, m_instr, m_id_pc, m_id_pc4, m_cnt;
    logic        m_valid, m_fault;

    always #5 clk = ~clk;

    assign im_instr = mem[im_addr[9:2]];

    fetch_stage #(.RESET_PC(32'h0), .IM_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .im_addr(im_addr), .im_instr(im_instr), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4), .id_valid(id_valid), .addr_fault(addr_fault), .fetch_cnt(fetch_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_id_pc = 32'h0; m_id_pc4 = 32'h0;
        m_valid = 1'b0; m_fault = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".im_addr"}, im_addr, m_pc);
        chk({tag, ".id_instr"}, id_instr, m_instr);
        chk({tag, ".id_pc"}, id_pc, m_id_pc);
        chk({tag, ".id_pc_plus4"}, id_pc_plus4, m_id_pc4);
        chk({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, m_valid});
        chk({tag, ".addr_fault"}, {31'b0, addr_fault}, {31'b0, m_fault});
        chk({tag, ".fetch_cnt"}, fetch_cnt, m_cnt);
    endtask

    // one clock edge with the given controls; the model follows the rules in priority order
    task automatic step(input logic s, input logic r, input logic [31:0] rpc, input string tag);
        logic inr;
        stall = s; redirect = r; redirect_pc = rpc;
        @(posedge clk);
        #1;
        stall = 1'b0; redirect = 1'b0;
        if (r) begin
            m_pc = rpc & 32'hFFFF_FFFC;
            m_valid = 1'b0;
            m_instr = 32'h0;
            if (rpc % 4 != 0) m_fault = 1'b1;
        end else if (!s) begin
            inr = m_pc < 32'd1024;
            m_instr = inr ? mem[m_pc[9:2]] : 32'h0;
            m_id_pc = m_pc;
            m_id_pc4 = m_pc + 32'd4;
            m_valid = inr;
            m_cnt = m_cnt + (inr ? 32'd1 : 32'd0);
            if (!inr) m_fault = 1'b1;
            m_pc = m_pc + 32'd4;
        end
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h0000_0123; stall = 1'b1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        chk({tag, ".im_addr_reset"}, im_addr, 32'h0);
        redirect = 1'b0; stall = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        model_reset();
        #2;
        check_all("reset");
        #10 rst_n = 1'b1;
        // run: words 0..3
        for (int i = 0; i < 4; i++) begin
            chk("run.im_addr_pre", im_addr, 32'(4 * i));
            step(1'b0, 1'b0, 32'h0, "run");
            chk("run.id_instr_word", id_instr, mem[i]);
        end
        chk("run.fetch_cnt4", fetch_cnt, 32'd4);
        chk("run.id_valid", {31'b0, id_valid}, 32'd1);
        // stall 3 cycles with id_pc=12, im_addr=16
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, "stall");
            chk("stall.id_pc_hold", id_pc, 32'd12);
            chk("stall.im_addr_hold", im_addr, 32'd16);
        end
        step(1'b0, 1'b0, 32'h0, "resume");
        chk("resume.id_pc", id_pc, 32'd16);
        // redirect to 0x40
        step(1'b0, 1'b1, 32'h40, "redir");
        chk("redir.im_addr", im_addr, 32'h40);
        chk("redir.bubble", {31'b0, id_valid}, 32'd0);
        step(1'b0, 1'b0, 32'h0, "redir_tgt");
        chk("redir_tgt.id_pc", id_pc, 32'h40);
        chk("redir_tgt.id_instr", id_instr, mem[16]);
        // redirect with stall
        step(1'b1, 1'b1, 32'h20, "redir_stall");
        chk("redir_stall.im_addr", im_addr, 32'h20);
        step(1'b1, 1'b0, 32'h0, "stall_bubble");
        step(1'b1, 1'b0, 32'h0, "stall_bubble");
        chk("stall_bubble.valid", {31'b0, id_valid}, 32'd0);
        step(1'b0, 1'b0, 32'h0, "release");
        chk("release.id_pc", id_pc, 32'h20);
        // misaligned redirect
        step(1'b0, 1'b1, 32'h22, "misalign");
        chk("misalign.im_addr", im_addr, 32'h20);
        chk("misalign.fault", {31'b0, addr_fault}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, "fault_sticky");
        chk("fault_sticky", {31'b0, addr_fault}, 32'd1);
        // async reset mid-redirect
        async_reset("areset");
        step(1'b0, 1'b0, 32'h0, "after_reset");
        chk("after_reset.id_instr", id_instr, mem[0]);
        // end of legal range
        step(1'b0, 1'b1, 32'h3F8, "range");
        step(1'b0, 1'b0, 32'h0, "range");
        step(1'b0, 1'b0, 32'h0, "range");
        chk("range.last_valid", {31'b0, id_valid}, 32'd1);
        chk("range.last_pc", id_pc, 32'h3FC);
        chk("range.no_fault_yet", {31'b0, addr_fault}, 32'd0);
        step(1'b0, 1'b0, 32'h0, "range_out");
        chk("range_out.valid", {31'b0, id_valid}, 32'd0);
        chk("range_out.fault", {31'b0, addr_fault}, 32'd1);
        // wrap-around at 2^32
        step(1'b0, 1'b1, 32'hFFFF_FFF8, "wrap");
        step(1'b0, 1'b0, 32'h0, "wrap");
        step(1'b0, 1'b0, 32'h0, "wrap");
        chk("wrap.im_addr", im_addr, 32'h0);
        chk("wrap.pc_plus4", id_pc_plus4, 32'h0);
        step(1'b0, 1'b0, 32'h0, "wrap_resume");
        chk("wrap_resume.valid", {31'b0, id_valid}, 32'd1);
        // randomized traffic
        async_reset("areset2");
        for (int i = 0; i < 400; i++) begin
            logic s, r;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 7) == 0);
            t = ($urandom_range(0, 9) == 0) ? $urandom : {22'b0, 8'($urandom), 2'b00};
            if ($urandom_range(0, 15) == 0) t[1:0] = 2'($urandom_range(1, 3));
            step(s, r, t, "rand");
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
